// File: rtl/little_cpu_pkg.sv
// Shared types and constants for the little CPU memory-side blocks.
package little_cpu_pkg;

  // Arbiter sequencing: pick a requester, drive the memory, hand back the result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  // Encoding of the rw pins shared by requesters and memory.
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Default datapath widths (MDR/memory word and MAR/PC address).
  localparam int BITS_DEF = 16;
  localparam int AW_DEF   = 8;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector: on a tie the requester that
// was not served last wins, otherwise whichever single requester is active.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  // Select the winner for the current cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path through this block can infer a latch.
    grant_valid_o = |req_i;
    grant_idx_o   = 1'b0;
    if (req_i == 2'b11) begin
      grant_idx_o = ~last_grant_i;
    end else begin
      grant_idx_o = req_i[1];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of the single-port memory. Requester 0 is
// the CPU MAR/MDR path, requester 1 the loader/debug port. One transaction
// at a time: IDLE picks a winner and latches its request, ACCESS drives the
// memory for 1 + MEM_WAIT cycles, DONE returns read data and pulses ack.
module mem_port_arbiter
  import little_cpu_pkg::*;
#(
  parameter int BITS     = BITS_DEF,
  parameter int AW       = AW_DEF,
  parameter int MEM_WAIT = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_r0_req,
  input  logic            i_r0_rw,
  input  logic [AW-1:0]   i_r0_addr,
  input  logic [BITS-1:0] i_r0_wdata,
  output logic            o_r0_ack,
  output logic [BITS-1:0] o_r0_rdata,
  input  logic            i_r1_req,
  input  logic            i_r1_rw,
  input  logic [AW-1:0]   i_r1_addr,
  input  logic [BITS-1:0] i_r1_wdata,
  output logic            o_r1_ack,
  output logic [BITS-1:0] o_r1_rdata,
  output logic            o_mem_rw,
  output logic [AW-1:0]   o_mem_addr,
  output logic [BITS-1:0] o_mem_wdata,
  input  logic [BITS-1:0] i_mem_rdata,
  output logic            o_busy
);

  // Index of the last ACCESS cycle; the wait counter runs 0..WAIT_LAST.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  arb_state_t      state_q;
  logic            last_grant_q;
  logic            gidx_q;
  logic            rw_q;
  logic            mem_rw_q;
  logic [3:0]      wait_q;
  logic [AW-1:0]   addr_q;
  logic [BITS-1:0] wdata_q;
  logic [BITS-1:0] r0_rdata_q;
  logic [BITS-1:0] r1_rdata_q;

  logic            grant_valid;
  logic            grant_idx;
  logic            done_read;

  rr_pick2 u_pick (
    .req_i         ({i_r1_req, i_r0_req}),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  // Arbitration FSM with request latches, wait counter and read-data capture.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gidx_q       <= 1'b0;
      rw_q         <= RW_READ;
      mem_rw_q     <= 1'b0;
      wait_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      r0_rdata_q   <= '0;
      r1_rdata_q   <= '0;
    end else begin
      // The write strobe is only ever a single-cycle pulse.
      mem_rw_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_valid) begin
            gidx_q   <= grant_idx;
            rw_q     <= grant_idx ? i_r1_rw    : i_r0_rw;
            mem_rw_q <= grant_idx ? i_r1_rw    : i_r0_rw;
            addr_q   <= grant_idx ? i_r1_addr  : i_r0_addr;
            wdata_q  <= grant_idx ? i_r1_wdata : i_r0_wdata;
            wait_q   <= '0;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_q == WAIT_LAST) begin
            state_q <= DONE;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        DONE: begin
          if (rw_q != RW_WRITE) begin
            if (gidx_q) r1_rdata_q <= i_mem_rdata;
            else        r0_rdata_q <= i_mem_rdata;
          end
          last_grant_q <= gidx_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data is already valid on i_mem_rdata during DONE, so the requester
  // sees it in the ack cycle and from the register afterwards.
  assign done_read   = (state_q == DONE) && (rw_q == RW_READ);
  assign o_r0_rdata  = (done_read && !gidx_q) ? i_mem_rdata : r0_rdata_q;
  assign o_r1_rdata  = (done_read &&  gidx_q) ? i_mem_rdata : r1_rdata_q;

  assign o_r0_ack    = (state_q == DONE) && !gidx_q;
  assign o_r1_ack    = (state_q == DONE) &&  gidx_q;

  // Reset masks the strobe immediately so no write commits on the reset edge.
  assign o_mem_rw    = mem_rw_q & ~i_rst;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_busy      = (state_q != IDLE);

endmodule
